vfr_frame_scheduler: RTL and testbench

Sequences the frame reader's read master from the control-register bank. It samples the go bit (enable) and the double-buffered frame descriptors (bank 0/1 base and word count). It issues one DMA frame command per frame and reports frame-complete and error interrupts back to the register bank. It drives the bank's stopped input and, in one-shot mode, its clear_enable input.

---
 rtl/vfr_frame_scheduler_pkg.sv | 22 ++
 rtl/vfr_frame_scheduler.sv | 131 +++++++++++++
 tb/tb_vfr_frame_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vfr_frame_scheduler_pkg.sv
// Purpose: shared types and constants for the frame reader's scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vfr_frame_scheduler_pkg;

    // Scheduler FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // Register indices of the scheduler's fields in the control bank.
    localparam int REG_BANK_SEL     = 3;
    localparam int REG_BASE0        = 4;
    localparam int REG_WORDS0       = 5;
    localparam int REG_BASE1        = 6;
    localparam int REG_WORDS1       = 7;
    localparam int CTRL_ONESHOT_BIT = 15;

endpackage

// File: rtl/vfr_frame_scheduler.sv
// Purpose: sequences the read master, issuing one DMA command per frame from the double-buffered descriptors.
// Latency: dma_start rises 2 cycles after enable is sampled; frame_irq/clear_enable follow dma_done by 1 cycle.
// Backpressure: dma_start is held with stable base/words until dma_ready; the next frame waits for dma_done.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   enable, oneshot          go bit and run-one-frame mode from the register bank
//   bank_sel, base*/words*   descriptor banks, sampled only in the LOAD cycle
//   dma_start/ready          frame command handshake; dma_base/dma_words are the latched descriptor
//   dma_done                 one-cycle pulse from the read master at end of frame
//   stopped, clear_enable    status and go-bit clear back to the register bank
//   frame_irq, err_irq       one-cycle interrupt pulses
//   active_bank, frame_count bank of the current/last frame; wrapping completed-frame counter
module vfr_frame_scheduler
    import vfr_frame_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORDS_WIDTH = 24,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   oneshot,
    input  logic                   bank_sel,
    input  logic [ADDR_WIDTH-1:0]  base0,
    input  logic [WORDS_WIDTH-1:0] words0,
    input  logic [ADDR_WIDTH-1:0]  base1,
    input  logic [WORDS_WIDTH-1:0] words1,
    output logic                   dma_start,
    input  logic                   dma_ready,
    output logic [ADDR_WIDTH-1:0]  dma_base,
    output logic [WORDS_WIDTH-1:0] dma_words,
    input  logic                   dma_done,
    output logic                   stopped,
    output logic                   clear_enable,
    output logic                   frame_irq,
    output logic                   err_irq,
    output logic                   active_bank,
    output logic [COUNT_WIDTH-1:0] frame_count
);

    state_t state;
    state_t state_nxt;
    state_t end_state;

    logic [ADDR_WIDTH-1:0]  sel_base;
    logic [WORDS_WIDTH-1:0] sel_words;
    logic                   zero_len;
    logic                   frame_end;
    logic                   desc_end;

    // Descriptor selected for the frame being loaded.
    assign sel_base  = bank_sel ? base1 : base0;
    assign sel_words = bank_sel ? words1 : words0;
    assign zero_len  = (sel_words == '0);

    // A real frame ends on dma_done in RUN; a zero-length descriptor ends in LOAD.
    assign frame_end = (state == ST_RUN) && dma_done;
    assign desc_end  = frame_end || ((state == ST_LOAD) && zero_len);

    // Where to go after a frame (or rejected descriptor) ends. oneshot wins
    // over enable because the go bit is being cleared in the same cycle.
    assign end_state = oneshot ? ST_IDLE : (enable ? ST_LOAD : ST_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Dropping enable never aborts a frame; it is only
    // consulted at the end-of-frame decision.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = zero_len ? end_state : ST_START;
            ST_START: if (dma_ready) state_nxt = ST_RUN;
            ST_RUN:   if (dma_done) state_nxt = end_state;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        dma_start = 1'b0;
        stopped   = 1'b0;
        case (state)
            ST_IDLE:  stopped   = 1'b1;
            ST_START: dma_start = 1'b1;
            default:  ;
        endcase
    end

    // Descriptor latch: held stable from one LOAD to the next so mid-frame
    // register writes only affect the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_bank <= 1'b0;
            dma_base    <= '0;
            dma_words   <= '0;
        end else if (state == ST_LOAD) begin
            active_bank <= bank_sel;
            dma_base    <= sel_base;
            dma_words   <= sel_words;
        end
    end

    // Event pulses and the completed-frame counter. Each pulse is registered
    // from a single-cycle condition, so it can never stretch past one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_irq    <= 1'b0;
            err_irq      <= 1'b0;
            clear_enable <= 1'b0;
            frame_count  <= '0;
        end else begin
            frame_irq    <= frame_end;
            err_irq      <= (state == ST_LOAD) && zero_len;
            clear_enable <= desc_end && oneshot;
            if (frame_end) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vfr_frame_scheduler.sv
// Purpose: directed self-checking bench for vfr_frame_scheduler.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: dma_ready/dma_done are driven directly by the directed steps.
module tb_vfr_frame_scheduler;

    localparam int AW = 32;
    localparam int WW = 24;
    // Narrow counter so the wrap can be reached in a short run.
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          oneshot;
    logic          bank_sel;
    logic [AW-1:0] base0;
    logic [WW-1:0] words0;
    logic [AW-1:0] base1;
    logic [WW-1:0] words1;
    logic          dma_start;
    logic          dma_ready;
    logic [AW-1:0] dma_base;
    logic [WW-1:0] dma_words;
    logic          dma_done;
    logic          stopped;
    logic          clear_enable;
    logic          frame_irq;
    logic          err_irq;
    logic          active_bank;
    logic [CW-1:0] frame_count;

    int vectors = 0;
    int miscompares = 0;

    vfr_frame_scheduler #(
        .ADDR_WIDTH  (AW),
        .WORDS_WIDTH (WW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .oneshot      (oneshot),
        .bank_sel     (bank_sel),
        .base0        (base0),
        .words0       (words0),
        .base1        (base1),
        .words1       (words1),
        .dma_start    (dma_start),
        .dma_ready    (dma_ready),
        .dma_base     (dma_base),
        .dma_words    (dma_words),
        .dma_done     (dma_done),
        .stopped      (stopped),
        .clear_enable (clear_enable),
        .frame_irq    (frame_irq),
        .err_irq      (err_irq),
        .active_bank  (active_bank),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        oneshot   = 1'b0;
        bank_sel  = 1'b0;
        base0     = '0;
        words0    = '0;
        base1     = '0;
        words1    = '0;
        dma_ready = 1'b0;
        dma_done  = 1'b0;
        tick();
        tick();

        // Reset values.
        chk("rst_stopped", 32'(stopped), 32'd1);
        chk("rst_dma_start", 32'(dma_start), 32'd0);
        chk("rst_dma_base", dma_base, 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_irqs", {29'd0, frame_irq, err_irq, clear_enable}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic frame from bank 0.
        base0    = 32'h1000;
        words0   = 24'd640;
        base1    = 32'h2000;
        words1   = 24'd100;
        enable   = 1'b1;
        tick();                                   // LOAD
        chk("load_stopped", 32'(stopped), 32'd0);
        chk("load_dma_start", 32'(dma_start), 32'd0);
        tick();                                   // START
        chk("start_dma_start", 32'(dma_start), 32'd1);
        chk("start_dma_base", dma_base, 32'h1000);
        chk("start_dma_words", 32'(dma_words), 32'd640);
        chk("start_bank", 32'(active_bank), 32'd0);
        dma_ready = 1'b1;
        tick();                                   // RUN
        chk("run_dma_start", 32'(dma_start), 32'd0);
        dma_ready = 1'b0;
        dma_done  = 1'b1;
        tick();                                   // LOAD again
        dma_done  = 1'b0;
        chk("f1_frame_irq", 32'(frame_irq), 32'd1);
        chk("f1_frame_count", 32'(frame_count), 32'd1);
        chk("f1_stopped", 32'(stopped), 32'd0);
        chk("f1_dma_start", 32'(dma_start), 32'd0);
        tick();                                   // START, second frame still bank 0
        chk("f2_irq_single", 32'(frame_irq), 32'd0);
        chk("f2_dma_start", 32'(dma_start), 32'd1);
        chk("f2_dma_base", dma_base, 32'h1000);

        // Bank swap written mid-frame only takes effect next frame.
        bank_sel  = 1'b1;
        base1     = 32'h8000;
        words1    = 24'd320;
        dma_ready = 1'b1;
        tick();                                   // RUN
        dma_ready = 1'b0;
        chk("swap_cur_base", dma_base, 32'h1000);
        chk("swap_cur_bank", 32'(active_bank), 32'd0);
        dma_done  = 1'b1;
        tick();                                   // LOAD
        dma_done  = 1'b0;
        chk("f2_frame_count", 32'(frame_count), 32'd2);
        tick();                                   // START, bank 1
        chk("swap_dma_base", dma_base, 32'h8000);
        chk("swap_dma_words", 32'(dma_words), 32'd320);
        chk("swap_bank", 32'(active_bank), 32'd1);

        // Backpressure: dma_start held 5 cycles with stable descriptor.
        chk("bp_start_c0", 32'(dma_start), 32'd1);
        for (int i = 1; i < 5; i++) begin
            base1  = 32'hDEAD0000 + 32'(i);
            words1 = 24'(i);
            tick();
            chk($sformatf("bp_start_c%0d", i), 32'(dma_start), 32'd1);
            chk($sformatf("bp_base_c%0d", i), dma_base, 32'h8000);
            chk($sformatf("bp_words_c%0d", i), 32'(dma_words), 32'd320);
        end
        dma_ready = 1'b1;
        tick();                                   // RUN
        dma_ready = 1'b0;
        chk("bp_released", 32'(dma_start), 32'd0);

        // Disable mid-frame: frame completes, then idle with no new command.
        enable = 1'b0;
        tick();
        chk("dis_still_run", 32'(stopped), 32'd0);
        dma_done = 1'b1;
        tick();                                   // IDLE
        dma_done = 1'b0;
        chk("dis_frame_irq", 32'(frame_irq), 32'd1);
        chk("dis_stopped", 32'(stopped), 32'd1);
        chk("dis_frame_count", 32'(frame_count), 32'd3);
        tick();
        tick();
        chk("dis_no_start", 32'(dma_start), 32'd0);
        chk("dis_stopped2", 32'(stopped), 32'd1);

        // One-shot frame.
        bank_sel = 1'b0;
        oneshot  = 1'b1;
        enable   = 1'b1;
        tick();                                   // LOAD
        tick();                                   // START
        chk("os_dma_start", 32'(dma_start), 32'd1);
        dma_ready = 1'b1;
        tick();                                   // RUN
        dma_ready = 1'b0;
        dma_done  = 1'b1;
        tick();                                   // IDLE
        dma_done  = 1'b0;
        chk("os_clear_enable", 32'(clear_enable), 32'd1);
        chk("os_frame_irq", 32'(frame_irq), 32'd1);
        chk("os_stopped", 32'(stopped), 32'd1);
        chk("os_frame_count", 32'(frame_count), 32'd4);
        enable = 1'b0;                            // register bank clears the go bit
        tick();
        chk("os_clear_single", 32'(clear_enable), 32'd0);
        chk("os_no_start", 32'(dma_start), 32'd0);
        oneshot = 1'b0;

        // Zero-length descriptor.
        words0 = 24'd0;
        enable = 1'b1;
        tick();                                   // LOAD
        enable = 1'b0;
        tick();                                   // IDLE
        chk("zl_err_irq", 32'(err_irq), 32'd1);
        chk("zl_no_start", 32'(dma_start), 32'd0);
        chk("zl_no_frame_irq", 32'(frame_irq), 32'd0);
        chk("zl_frame_count", 32'(frame_count), 32'd4);
        chk("zl_stopped", 32'(stopped), 32'd1);
        tick();
        chk("zl_err_single", 32'(err_irq), 32'd0);
        chk("zl_no_start2", 32'(dma_start), 32'd0);

        // Reset while a frame is running.
        words0 = 24'd8;
        enable = 1'b1;
        tick();                                   // LOAD
        tick();                                   // START
        dma_ready = 1'b1;
        tick();                                   // RUN
        dma_ready = 1'b0;
        chk("rr_running", 32'(stopped), 32'd0);
        enable = 1'b0;
        rst    = 1'b1;
        #1;
        chk("rr_stopped", 32'(stopped), 32'd1);
        chk("rr_dma_base", dma_base, 32'd0);
        chk("rr_dma_words", 32'(dma_words), 32'd0);
        chk("rr_frame_count", 32'(frame_count), 32'd0);
        chk("rr_dma_start", 32'(dma_start), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Counter wrap: 2^CW back-to-back frames return the count to 0.
        enable    = 1'b1;
        dma_ready = 1'b1;
        tick();                                   // LOAD
        for (int f = 1; f <= (1 << CW); f++) begin
            tick();                               // START
            tick();                               // RUN
            dma_done = 1'b1;
            tick();                               // LOAD, count updated
            dma_done = 1'b0;
            if (f == (1 << CW) - 1) begin
                chk("wrap_max", 32'(frame_count), 32'((1 << CW) - 1));
            end
        end
        chk("wrap_zero", 32'(frame_count), 32'd0);
        chk("wrap_frame_irq", 32'(frame_irq), 32'd1);
        enable    = 1'b0;
        dma_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
